axi4_mm2s_reader: RTL and testbench
===================================

# axi4_mm2s_reader

- Memory-to-stream read engine of the AXI4 DMA.
- On a `start` pulse it fetches `num_beats` data words from memory over an AXI4 master read channel, splitting the transfer into INCR bursts.
- Data is buffered in an internal FIFO and emitted on an AXI4-Stream master.
- Sits between the DMA control registers (AXI4-Lite side) and the downstream stream consumer. The write channels of the AXI4 master port are tied off here.

## Interface
Parameters:
- `C_AXI_ID_WIDTH`, 1: AXI ID width.
- `C_AXI_ADDR_WIDTH`, 32: AXI address width.
- `C_AXI_DATA_WIDTH`, 32: AXI and stream data width; power of two, 32..256.
- `C_AXI_BURST_LEN`, 16: maximum beats per burst, 1..256.
- `FIFO_DEPTH`, 32: buffer entries; power of two, at least `C_AXI_BURST_LEN`.

Ports:
- `aclk`  in  1  clock.
- `arstn`  in  1  reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  single-cycle request; ignored while `busy`.
- `src_addr`  in  C_AXI_ADDR_WIDTH  byte start address, sampled at `start`; low log2(DATA/8) bits forced to zero.
- `num_beats`  in  16  beat count, sampled at `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at completion.
- `error`  out  1  sticky: set on any `rresp != 2'b00`; cleared by the next accepted `start`.
- `m_axi`  axi4_master_if.master  read channels used; `awvalid`, `wvalid` = 0, `bready` = 1, other AW/W outputs = 0.
- `m_axis`  axi4_stream_if.master  output data stream.

## Operation
- State machine:
  - IDLE:
    - `start` with `num_beats` = 0 → pulse `done` next cycle, no AR issued.
    - `start` with `num_beats` ≠ 0 → latch `addr` and `remaining`; go to ADDR.
  - ADDR:
    - Compute `blen` = min(`remaining`, `C_AXI_BURST_LEN`, beats to next 4 KB boundary). Beats to boundary = (4096 − `addr[11:0]`) / (DATA/8).
    - Wait until FIFO free entries ≥ `blen`, then drive `arvalid` with:
      - `araddr` = `addr`, `arlen` = `blen` − 1
      - `arsize` = log2(DATA/8), `arburst` = 2'b01, `arid` = 0
    - On `arready`, go to DATA.
  - DATA:
    - `rready` = 1 for the whole burst; space is reserved in ADDR, so no stall.
    - Push every R beat into the FIFO, including beats with error responses.
    - On the `rlast` handshake: `addr` += `blen`·DATA/8 and `remaining` −= `blen`. Go to ADDR if `remaining` ≠ 0, else DRAIN.
  - DRAIN: when the FIFO is empty and no stream handshake is pending, pulse `done` and go to IDLE.
- At most one outstanding AR; `rid` and `rlast` are not checked against the beat count.
- FIFO → stream runs independently of the state machine: `tvalid` = FIFO not empty, `tdata` = FIFO head, pop on `tvalid && tready`.
- Arithmetic: `remaining` is 16 bits; `addr` wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset values: `arvalid`, `rready`, `tvalid`, `busy`, `done`, `error` = 0; `araddr`, `arlen` = 0; FIFO empty; state IDLE.
- `arvalid` is registered: it rises ≥1 cycle after entering ADDR and holds `araddr`/`arlen` stable until `arready`.
- R-to-stream latency: a beat pushed in cycle N is visible on `tvalid` in cycle N+1.
- Full FIFO:
  - No AR is issued until space for a full burst exists.
  - A push and pop in the same cycle keep the occupancy unchanged.
- `tvalid`/`tdata` hold until `tready`; stream beat order equals R beat order.
- `start` while `busy`: ignored, with no effect on latched values.
- `arstn` low mid-transfer: all state, FIFO and outputs return to reset values immediately. The AXI transaction in flight is abandoned; a new `start` is required.

## Structure
- `dma_pkg`: AXI burst constants (FIXED/INCR/WRAP), resp constants (OKAY/EXOKAY/SLVERR/DECERR), 4 KB boundary constant, MM2S state enum.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): single-clock FIFO with full/empty/count outputs. It is reusable by the S2MM writer.

## Test plan
- `src_addr`=0x1000, `num_beats`=1 → one AR with `araddr`=0x1000, `arlen`=0; one stream beat equal to R data; `done` pulses once; `busy` low afterwards.
- `src_addr`=0x0, `num_beats`=40, DATA=32, BURST=16 → ARs `arlen` 15/15/7 at 0x00/0x40/0x80; 40 stream beats in order.
- `src_addr`=0xFF8, `num_beats`=4 → AR `arlen`=1 @0xFF8, then AR `arlen`=1 @0x1000; no burst crosses 4 KB.
- Random `tready` (30% low), `arready` delayed 5 cycles, 100 beats → no loss or duplication; `rready` never deasserts mid-burst; FIFO never overflows.
- `rresp`=SLVERR on beat 3 of 8 → `error` set and held; all 8 beats still streamed; `done` pulses; next `start` clears `error`.
- `num_beats`=0 → `done` next cycle, no AR. `start` while busy → ignored. `arstn` low mid-burst → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA engines: AXI burst and response encodings,
// the 4 KB burst boundary and the MM2S reader state encoding.
package dma_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // An AXI burst may not cross a 4 KB address boundary.
  localparam logic [12:0] BOUNDARY_4K = 13'd4096;

  typedef enum logic [1:0] {
    MM2S_IDLE,
    MM2S_ADDR,
    MM2S_DATA,
    MM2S_DRAIN
  } mm2s_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, first-word fall-through (dout_o is the head entry).
// Ports: clk_i/rst_ni (async active-low), push_i/din_i write side,
// pop_i/dout_o read side, full_o/empty_o flags, count_o occupancy.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/axi4_mm2s_reader.sv
// Memory-to-stream read engine. A start pulse fetches num_beats words from
// src_addr over the AXI4 read channels as INCR bursts (bounded by the burst
// length, the remaining count and the 4 KB boundary), buffers them in a FIFO
// and emits them on an AXI4-Stream master. Write channels are tied off.
// Ports: aclk/arstn (async active-low), start/src_addr/num_beats command,
// busy/done/error status, m_axi_* AXI4 master, m_axis_* stream master.
module axi4_mm2s_reader
  import dma_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH   = 1,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_BURST_LEN  = 16,
  parameter int FIFO_DEPTH       = 32
) (
  input  logic                          aclk,
  input  logic                          arstn,
  input  logic                          start,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   src_addr,
  input  logic [15:0]                   num_beats,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [C_AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_AXI_ID_WIDTH-1:0]     m_axi_rid,
  input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic [C_AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [C_AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_AXI_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready
);

  localparam int AW    = C_AXI_ADDR_WIDTH;
  localparam int BYTES = C_AXI_DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  mm2s_state_e      state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [15:0]      remaining_q, remaining_d;
  logic [15:0]      blen_q, blen_d;
  logic             arvalid_q, arvalid_d;
  logic [AW-1:0]    araddr_q, araddr_d;
  logic [7:0]       arlen_q, arlen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic [12:0]      to_bound;
  logic [15:0]      blen_calc;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] fifo_free;
  logic             fifo_empty, fifo_full, fifo_push;
  logic             r_hs;
  logic             unused_sig;

  sync_fifo #(
    .WIDTH (C_AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (aclk),
    .rst_ni  (arstn),
    .push_i  (fifo_push),
    .din_i   (m_axi_rdata),
    .pop_i   (m_axis_tready),
    .dout_o  (m_axis_tdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign fifo_free     = CNT_W'(FIFO_DEPTH) - fifo_count;
  assign r_hs          = m_axi_rvalid && m_axi_rready;

  // Burst length: min(remaining, max burst, beats left before the 4 KB line).
  // addr_q is always beat-aligned, so the shift divides exactly.
  always_comb begin
    to_bound  = (BOUNDARY_4K - {1'b0, addr_q[11:0]}) >> SIZE;
    blen_calc = remaining_q;
    if (16'(C_AXI_BURST_LEN) < blen_calc) blen_calc = 16'(C_AXI_BURST_LEN);
    if ({3'b000, to_bound} < blen_calc)   blen_calc = {3'b000, to_bound};
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= MM2S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      blen_q      <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      blen_q      <= blen_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    blen_d      = blen_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    if (r_hs && (m_axi_rresp != RESP_OKAY)) error_d = 1'b1;
    case (state_q)
      MM2S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (num_beats == 16'd0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = src_addr & ~AW'(BYTES - 1);
            remaining_d = num_beats;
            busy_d      = 1'b1;
            state_d     = MM2S_ADDR;
          end
        end
      end
      MM2S_ADDR: begin
        // Only the engine pushes into the FIFO, so free space cannot shrink
        // between this check and the end of the burst.
        if (!arvalid_q) begin
          if (16'(fifo_free) >= blen_calc) begin
            arvalid_d = 1'b1;
            araddr_d  = addr_q;
            arlen_d   = 8'(blen_calc - 16'd1);
            blen_d    = blen_calc;
          end
        end else if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = MM2S_DATA;
        end
      end
      MM2S_DATA: begin
        if (r_hs && m_axi_rlast) begin
          addr_d      = addr_q + (AW'(blen_q) << SIZE);
          remaining_d = remaining_q - blen_q;
          state_d     = (remaining_q == blen_q) ? MM2S_DRAIN : MM2S_ADDR;
        end
      end
      MM2S_DRAIN: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = MM2S_IDLE;
        end
      end
      default: state_d = MM2S_IDLE;
    endcase
  end

  always_comb begin
    m_axi_rready = (state_q == MM2S_DATA);
    fifo_push    = m_axi_rvalid && m_axi_rready;
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arvalid = arvalid_q;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = '0;
  assign m_axi_awlen   = '0;
  assign m_axi_awsize  = '0;
  assign m_axi_awburst = '0;
  assign m_axi_awvalid = 1'b0;
  assign m_axi_wdata   = '0;
  assign m_axi_wstrb   = '0;
  assign m_axi_wlast   = 1'b0;
  assign m_axi_wvalid  = 1'b0;
  assign m_axi_bready  = 1'b1;

  // rid/rlast beyond the burst are not checked; write responses are ignored.
  assign unused_sig = ^{m_axi_rid, m_axi_awready, m_axi_wready, m_axi_bid,
                        m_axi_bresp, m_axi_bvalid, fifo_full};

endmodule

// File: tb/tb_axi4_mm2s_reader.sv
module tb_axi4_mm2s_reader;
  localparam int IDW = 1, AW = 32, DW = 32, BL = 16, FD = 32, BYTES = DW / 8;

  logic aclk = 1'b0;
  logic arstn;
  always #5 aclk = ~aclk;

  logic start, busy, done, error;
  logic [AW-1:0] src_addr;
  logic [15:0] num_beats;
  logic [IDW-1:0] arid, rid, awid, bid;
  logic [AW-1:0] araddr, awaddr;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic [DW-1:0] rdata, wdata, tdata;
  logic [DW/8-1:0] wstrb;
  logic wlast, wvalid, wready, bvalid, bready, tvalid, tready;

  axi4_mm2s_reader #(
    .C_AXI_ID_WIDTH(IDW), .C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW),
    .C_AXI_BURST_LEN(BL), .FIFO_DEPTH(FD)
  ) dut (
    .aclk(aclk), .arstn(arstn), .start(start), .src_addr(src_addr), .num_beats(num_beats),
    .busy(busy), .done(done), .error(error),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  int n_vec = 0, n_err = 0;
  ar_t exp_ar[$];
  logic [31:0] exp_data[$];
  ar_t bursts[$];
  int done_cnt = 0;
  int ar_delay = 0, ar_wait = 0, tready_low = 0, r_beat = 0;
  bit err_en = 0;
  logic [31:0] err_addr = '0;

  // Memory contents seen by the slave model: a fixed hash of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got 0x%0h, nothing expected", name, act);
  endtask

  // AXI slave, stream sink and scoreboard monitor.
  initial begin
    bit ar_hs, r_hs, ar_pend;
    logic [31:0] ar_prev, ra;
    ar_t e;
    ar_hs = 0; r_hs = 0; ar_pend = 0; ar_prev = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00; rlast = 0; rid = '0;
    tready = 0; awready = 0; wready = 0; bid = '0; bresp = 2'b00; bvalid = 0;
    forever begin
      @(negedge aclk);
      ar_hs = arstn && arvalid && arready;
      r_hs  = arstn && rvalid && rready;
      if (arstn && arvalid && ar_pend) chk("araddr_stable", araddr, ar_prev);
      ar_pend = arstn && arvalid && !arready;
      ar_prev = araddr;
      if (arstn && rvalid) chk("rready_held", rready, 1);
      if (ar_hs) begin
        if (exp_ar.size() == 0) fail("ar_unexpected", araddr);
        else begin
          e = exp_ar.pop_front();
          chk("araddr", araddr, e.addr);
          chk("arlen", arlen, e.len);
          chk("arsize", arsize, 3'd2);
          chk("arburst", arburst, 2'b01);
          e.addr = araddr;
          e.len  = arlen;
          bursts.push_back(e);
        end
      end
      if (arstn && tvalid && tready) begin
        if (exp_data.size() == 0) fail("stream_extra", tdata);
        else chk("tdata", tdata, exp_data.pop_front());
      end
      if (arstn && done) done_cnt++;
      @(posedge aclk);
      #1;
      if (!arstn) begin
        arready = 0; rvalid = 0; rlast = 0; rresp = 2'b00;
        bursts.delete(); ar_wait = 0; r_beat = 0; ar_pend = 0;
      end else begin
        if (ar_hs) begin
          arready = 0;
          ar_wait = 0;
        end else if (arvalid && !arready) begin
          if (ar_wait >= ar_delay) arready = 1;
          else ar_wait++;
        end
        if (r_hs) begin
          if (rlast) begin
            e = bursts.pop_front();
            r_beat = 0;
          end else r_beat++;
        end
        rvalid = 0; rlast = 0; rresp = 2'b00;
        if (bursts.size() > 0 && $urandom_range(0, 3) != 0) begin
          ra     = bursts[0].addr + 32'(r_beat * BYTES);
          rvalid = 1;
          rdata  = mem_word(ra);
          rlast  = (r_beat == int'(bursts[0].len));
          rresp  = (err_en && ra == err_addr) ? 2'b10 : 2'b00;
        end
      end
      tready = ($urandom_range(0, 99) >= tready_low);
    end
  end

  // Reference model: expected ARs and stream words for one command.
  task automatic set_expect(input logic [31:0] a, input int n, input int eb);
    logic [31:0] ca;
    int rem, b, bnd;
    ar_t e;
    ca  = a & ~32'(BYTES - 1);
    rem = n;
    while (rem > 0) begin
      b   = (rem < BL) ? rem : BL;
      bnd = (4096 - int'(ca[11:0])) / BYTES;
      if (b > bnd) b = bnd;
      e.addr = ca;
      e.len  = 8'(b - 1);
      exp_ar.push_back(e);
      for (int i = 0; i < b; i++) exp_data.push_back(mem_word(ca + 32'(i * BYTES)));
      ca  = ca + 32'(b * BYTES);
      rem = rem - b;
    end
    err_en   = (eb >= 0 && eb < n);
    err_addr = (a & ~32'(BYTES - 1)) + 32'(eb * BYTES);
  endtask

  task automatic pulse_start(input logic [31:0] a, input int n);
    src_addr  = a;
    num_beats = 16'(n);
    start     = 1;
    @(posedge aclk);
    #1;
    start = 0;
  endtask

  task automatic run(input logic [31:0] a, input int n, input int eb, input int trl,
                     input int ard, input bit poke);
    int d0;
    bit exp_err;
    set_expect(a, n, eb);
    exp_err    = err_en;
    tready_low = trl;
    ar_delay   = ard;
    d0 = done_cnt;
    pulse_start(a, n);
    chk("error_cleared", error, 0);
    if (n == 0) begin
      chk("done_zero", done, 1);
      chk("busy_zero", busy, 0);
    end else chk("busy_after_start", busy, 1);
    if (poke) begin
      repeat (3) @(posedge aclk);
      #1;
      pulse_start(32'h8000, 5);
      chk("busy_poke", busy, 1);
    end
    for (int i = 0; i < 5000 && done_cnt == d0; i++) @(posedge aclk);
    if (done_cnt == d0) fail("timeout_done", 64'(n));
    #1;
    chk("done_pulse", done, 0);
    chk("busy_end", busy, 0);
    chk("done_count", 64'(done_cnt - d0), 1);
    chk("ar_left", 64'(exp_ar.size()), 0);
    chk("data_left", 64'(exp_data.size()), 0);
    chk("error_sticky", error, exp_err);
    exp_ar.delete();
    exp_data.delete();
    repeat (2) @(posedge aclk);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    int rn, re;
    arstn = 0; start = 0; src_addr = '0; num_beats = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("tie_awvalid", awvalid, 0);
    chk("tie_wvalid", wvalid, 0);
    chk("tie_bready", bready, 1);
    arstn = 1;
    @(posedge aclk);
    #1;

    run(32'h1000, 1, -1, 0, 0, 0);
    run(32'h0, 40, -1, 0, 0, 0);
    run(32'hFF8, 4, -1, 0, 0, 0);
    run(32'h2000, 100, -1, 30, 5, 0);
    run(32'h3000, 8, 2, 30, 1, 0);
    run(32'h3100, 0, -1, 0, 0, 0);
    run(32'h4000, 20, -1, 10, 2, 1);
    for (int k = 0; k < 6; k++) begin
      ra = 32'($urandom_range(0, 32'h7FFF)) << 2;
      rn = $urandom_range(1, 70);
      re = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rn - 1) : -1;
      run(ra, rn, re, $urandom_range(0, 50), $urandom_range(0, 4), 0);
    end

    // Reset in the middle of a burst.
    set_expect(32'h5000, 40, -1);
    tready_low = 20;
    ar_delay   = 1;
    pulse_start(32'h5000, 40);
    for (int i = 0; i < 2000 && !(bursts.size() > 0 && r_beat >= 2); i++) @(posedge aclk);
    if (!(bursts.size() > 0 && r_beat >= 2)) fail("timeout_midburst", 64'(r_beat));
    @(negedge aclk);
    #2;
    arstn = 0;
    #1;
    chk("mid_arvalid", arvalid, 0);
    chk("mid_rready", rready, 0);
    chk("mid_tvalid", tvalid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_error", error, 0);
    chk("mid_araddr", araddr, 0);
    chk("mid_arlen", arlen, 0);
    exp_ar.delete();
    exp_data.delete();
    err_en = 0;
    repeat (3) @(posedge aclk);
    #1;
    arstn = 1;
    @(posedge aclk);
    #1;
    run(32'hFFC0, 20, 5, 30, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
